// File: rtl/trap_sequencer.sv
// Trap/return sequencer: saves EPC and cause, vectors on syscall or interrupt, and handles ERET.
// Optional macro TRAP_VECTORED_EN gives each interrupt line its own vector slot.
module trap_sequencer #(
    parameter int unsigned N_IRQ    = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000_0004
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boundary,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             ie,
    input  logic             syscall_req,
    input  logic             eret_req,
    input  logic [31:0]      pc_cur,
    input  logic [31:0]      epc_in,
    output logic             c0_write,
    output logic [1:0]       c0_dst,
    output logic [31:0]      c0_wdata,
    output logic             pc_write,
    output logic [31:0]      pc_next,
    output logic             ie_clr,
    output logic             ie_set,
    output logic [N_IRQ-1:0] irq_ack,
    output logic             busy
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SAVE_EPC   = 3'd1;
    localparam logic [2:0] S_SAVE_CAUSE = 3'd2;
    localparam logic [2:0] S_VECTOR     = 3'd3;
    localparam logic [2:0] S_ERET_RD    = 3'd4;
    localparam logic [2:0] S_ERET_JMP   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      cause_q, cause_d;
    logic [N_IRQ-1:0] pend_en;
    logic [2:0]       low_idx;
    logic             irq_take;
    logic [31:0]      vec_addr;

    // Scan high to low so the lowest enabled pending line is written last.
    always_comb begin
        pend_en = pend_q & irq_mask;
        low_idx = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (pend_en[N_IRQ-1-i]) low_idx = 3'(N_IRQ-1-i);
        end
        irq_take = ie & (|pend_en);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cause_d = cause_q;
        pend_d  = (pend_q & ~irq_ack) | irq;
        case (state_q)
            S_IDLE: begin
                if (boundary) begin
                    if (eret_req) begin
                        state_d = S_ERET_RD;
                    end else if (syscall_req) begin
                        state_d = S_SAVE_EPC;
                        cause_d = 32'h0000_0020;
                    end else if (irq_take) begin
                        state_d = S_SAVE_EPC;
                        idx_d   = low_idx;
                        cause_d = {1'b1, 24'b0, 2'b00, low_idx, 2'b00};
                    end
                end
            end
            S_SAVE_EPC:   state_d = S_SAVE_CAUSE;
            S_SAVE_CAUSE: state_d = S_VECTOR;
            S_VECTOR:     state_d = S_IDLE;
            S_ERET_RD:    state_d = S_ERET_JMP;
            S_ERET_JMP:   state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
`ifdef TRAP_VECTORED_EN
        vec_addr = cause_q[31] ? VEC_BASE + (({29'd0, idx_q} + 32'd1) << 3) : VEC_BASE;
`else
        vec_addr = VEC_BASE;
`endif
    end

    always_comb begin
        c0_write = 1'b0;
        c0_dst   = 2'b00;
        c0_wdata = '0;
        pc_write = 1'b0;
        pc_next  = '0;
        ie_clr   = 1'b0;
        ie_set   = 1'b0;
        irq_ack  = '0;
        case (state_q)
            S_SAVE_EPC: begin
                c0_write = 1'b1;
                c0_dst   = 2'b10;
                c0_wdata = pc_cur;
                ie_clr   = 1'b1;
            end
            S_SAVE_CAUSE: begin
                c0_write = 1'b1;
                c0_dst   = 2'b01;
                c0_wdata = cause_q;
            end
            S_VECTOR: begin
                pc_write = 1'b1;
                pc_next  = vec_addr;
                if (cause_q[31]) irq_ack = N_IRQ'(1) << idx_q;
            end
            S_ERET_RD: c0_dst = 2'b10;
            S_ERET_JMP: begin
                pc_write = 1'b1;
                pc_next  = epc_in;
                ie_set   = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            idx_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios plus random traffic against a queue-based expectation model.
module tb_trap_sequencer;
    localparam int          N  = 4;
    localparam logic [31:0] VB = 32'h0000_0004;
`ifdef TRAP_VECTORED_EN
    localparam bit VECTORED = 1'b1;
`else
    localparam bit VECTORED = 1'b0;
`endif

    logic          clk, rst, boundary, ie, syscall_req, eret_req;
    logic [N-1:0]  irq, irq_mask, irq_ack;
    logic [31:0]   pc_cur, epc_in, c0_wdata, pc_next;
    logic          c0_write, pc_write, ie_clr, ie_set, busy;
    logic [1:0]    c0_dst;

    trap_sequencer #(.N_IRQ(N), .VEC_BASE(VB)) dut (
        .clk(clk), .rst(rst), .boundary(boundary), .irq(irq), .irq_mask(irq_mask),
        .ie(ie), .syscall_req(syscall_req), .eret_req(eret_req), .pc_cur(pc_cur),
        .epc_in(epc_in), .c0_write(c0_write), .c0_dst(c0_dst), .c0_wdata(c0_wdata),
        .pc_write(pc_write), .pc_next(pc_next), .ie_clr(ie_clr), .ie_set(ie_set),
        .irq_ack(irq_ack), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One entry per busy cycle: what the outputs must show during that cycle.
    typedef struct packed {
        bit        wr;
        bit [1:0]  dst;
        bit        wd_pc;
        bit [31:0] wd;
        bit        pcw;
        bit        pn_epc;
        bit [31:0] pn;
        bit        clr;
        bit        set;
        bit [N-1:0] ack;
    } exp_t;

    exp_t   q[$];
    bit [N-1:0] m_pend;

    task automatic push_trap(input bit is_irq, input int idx);
        exp_t e;
        e = '0; e.wr = 1; e.dst = 2'b10; e.wd_pc = 1; e.clr = 1;
        q.push_back(e);
        e = '0; e.wr = 1; e.dst = 2'b01;
        e.wd = is_irq ? (32'h8000_0000 | 32'(idx * 4)) : 32'h0000_0020;
        q.push_back(e);
        e = '0; e.pcw = 1;
        e.pn = (VECTORED && is_irq) ? VB + 32'(8 * (idx + 1)) : VB;
        e.ack = is_irq ? N'(1 << idx) : '0;
        q.push_back(e);
    endtask

    task automatic push_eret();
        exp_t e;
        e = '0; e.dst = 2'b10;
        q.push_back(e);
        e = '0; e.pcw = 1; e.pn_epc = 1; e.set = 1;
        q.push_back(e);
    endtask

    task automatic model_edge();
        exp_t cur;
        bit was_busy;
        bit [N-1:0] pn;
        was_busy = (q.size() != 0);
        cur = was_busy ? q.pop_front() : '0;
        pn = (m_pend & ~cur.ack) | irq;
        if (!was_busy && boundary) begin
            if (eret_req) push_eret();
            else if (syscall_req) push_trap(1'b0, 0);
            else if (ie) begin
                for (int i = 0; i < N; i++) begin
                    if (m_pend[i] && irq_mask[i]) begin
                        push_trap(1'b1, i);
                        break;
                    end
                end
            end
        end
        m_pend = pn;
    endtask

    task automatic compare(input string tag);
        exp_t e;
        e = (q.size() != 0) ? q[0] : '0;
        check({tag, "/busy"},     32'(busy),     32'(q.size() != 0));
        check({tag, "/c0_write"}, 32'(c0_write), 32'(e.wr));
        check({tag, "/c0_dst"},   32'(c0_dst),   32'(e.dst));
        check({tag, "/c0_wdata"}, c0_wdata,      e.wd_pc ? pc_cur : e.wd);
        check({tag, "/pc_write"}, 32'(pc_write), 32'(e.pcw));
        check({tag, "/pc_next"},  pc_next,       e.pn_epc ? epc_in : e.pn);
        check({tag, "/ie_clr"},   32'(ie_clr),   32'(e.clr));
        check({tag, "/ie_set"},   32'(ie_set),   32'(e.set));
        check({tag, "/irq_ack"},  32'(irq_ack),  32'(e.ack));
        check({tag, "/pend"},     32'(dut.pend_q), 32'(m_pend));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    initial begin
        rst = 1'b1; boundary = 1'b0; ie = 1'b1; syscall_req = 1'b0; eret_req = 1'b0;
        irq = '0; irq_mask = '1; pc_cur = '0; epc_in = '0;
        m_pend = '0;
        #2;
        compare("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        compare("post_reset");

        // Syscall from pc 0x100
        pc_cur = 32'h100; boundary = 1'b1; syscall_req = 1'b1;
        step("sys_dec");
        check("sys_epc_val", c0_wdata, 32'h100);
        check("sys_epc_dst", 32'(c0_dst), 32'd2);
        syscall_req = 1'b0; boundary = 1'b0;
        step("sys_cause");
        check("sys_cause_val", c0_wdata, 32'h20);
        step("sys_vec");
        check("sys_vec_pc", pc_next, VB);
        step("sys_done");
        check("sys_idle", 32'(busy), 32'd0);

        // Two pending lines, lowest wins, second taken afterwards
        irq = 4'b0110; irq_mask = 4'b1111; ie = 1'b1; boundary = 1'b0;
        step("irq_latch");
        irq = '0; boundary = 1'b1;
        step("irq_dec");
        step("irq_cause");
        check("irq_cause_val", c0_wdata, 32'h8000_0004);
        step("irq_vec");
        check("irq_ack_l1", 32'(irq_ack), 32'h2);
        check("irq_vec_pc", pc_next, VECTORED ? 32'h14 : VB);
        repeat (5) step("irq_second");
        boundary = 1'b0;
        step("irq_quiet");

        // Masked line must wait for its mask bit
        irq_mask = 4'b1011; irq = 4'b0100;
        step("mask_latch");
        irq = '0; boundary = 1'b1;
        repeat (3) step("mask_hold");
        check("mask_no_trap", 32'(busy), 32'd0);
        irq_mask = 4'b1111;
        step("mask_take");
        check("mask_trap", 32'(busy), 32'd1);
        repeat (4) step("mask_run");

        // Return beats syscall
        boundary = 1'b1; eret_req = 1'b1; syscall_req = 1'b1; epc_in = 32'h200;
        step("eret_rd");
        eret_req = 1'b0; syscall_req = 1'b0; boundary = 1'b0;
        step("eret_jmp");
        check("eret_pc", pc_next, 32'h200);
        check("eret_ie_set", 32'(ie_set), 32'd1);
        step("eret_done");

        // Reset during SAVE_CAUSE
        boundary = 1'b1; syscall_req = 1'b1; irq = 4'b0001;
        step("rst_dec");
        syscall_req = 1'b0; boundary = 1'b0; irq = '0;
        step("rst_cause");
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pc_write", 32'(pc_write), 32'd0);
        check("rst_c0_write", 32'(c0_write), 32'd0);
        check("rst_pend", 32'(dut.pend_q), 32'd0);
        q.delete();
        m_pend = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        compare("rst_after");
        check("rst_no_pcw", 32'(pc_write), 32'd0);

        // Interrupt arriving during VECTOR of a syscall
        boundary = 1'b1; syscall_req = 1'b1;
        step("late_dec");
        syscall_req = 1'b0; boundary = 1'b0;
        step("late_cause");
        step("late_vec");
        irq = 4'b0001;
        step("late_idle");
        irq = '0; boundary = 1'b1;
        step("late_take");
        check("late_busy", 32'(busy), 32'd1);
        step("late_cause2");
        step("late_vec2");
        check("late_ack", 32'(irq_ack), 32'h1);
        step("late_done");
        boundary = 1'b0;
        step("late_quiet");

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            boundary    = 1'($urandom_range(0, 1));
            syscall_req = ($urandom_range(0, 7) == 0);
            eret_req    = ($urandom_range(0, 9) == 0);
            irq         = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) irq_mask = N'($urandom);
            ie          = ($urandom_range(0, 3) != 0);
            pc_cur      = $urandom & 32'hFFFF_FFFC;
            epc_in      = $urandom;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 The block SHALL have parameter N_IRQ, default 4, giving the number of interrupt lines (legal 1..8).
REQ-002 The block SHALL have parameter VEC_BASE, default 32'h0000_0004, giving the trap vector base address.
REQ-003 The block SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have boundary  input  1  the core is at an instruction boundary (fetch state), so a trap or return may start.
REQ-006 The block SHALL have irq  input  N_IRQ  interrupt request levels.
REQ-007 The block SHALL have irq_mask  input  N_IRQ  per-line enable from C0 status.
REQ-008 The block SHALL have ie  input  1  global interrupt enable from C0 status.
REQ-009 The block SHALL have syscall_req and eret_req  inputs  1 each  decoded instruction requests, qualified by boundary.
REQ-010 The block SHALL have pc_cur and epc_in  inputs  32 each  current PC and C0 EPC read value.
REQ-011 The block SHALL have c0_write (output, 1), c0_dst (output, 2; 00 status, 01 cause, 10 EPC) and c0_wdata (output, 32)  C0 write port.
REQ-012 The block SHALL have pc_write (output, 1) and pc_next (output, 32)  PC load.
REQ-013 The block SHALL have ie_clr and ie_set  outputs  1 each  single-cycle global-enable clear/set strobes.
REQ-014 The block SHALL have irq_ack  output  N_IRQ  one-hot acknowledge of the serviced line.
REQ-015 The block SHALL have busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The pending register SHALL update each cycle as pend <= (pend & ~irq_ack) | irq; set dominates clear on the same line.
REQ-017 The states SHALL be IDLE, SAVE_EPC, SAVE_CAUSE, VECTOR, ERET_RD and ERET_JMP; all outputs SHALL be Moore-decoded from the state.
REQ-018 In IDLE with boundary=1, the request SHALL be selected by priority eret_req > syscall_req > interrupt (ie & |(pend & irq_mask)).
REQ-019 Among interrupts, the lowest index SHALL win; index and cause SHALL be captured into idx_q/cause_q at the decision edge.
REQ-020 cause_q SHALL be 32'h0000_0020 for a syscall (code 8 in bits 6:2), and {1'b1, 23'b0, 3'b0, idx, 2'b0}-style bit31=1 with the index in bits 6:2 for an interrupt.
REQ-021 A trap SHALL sequence IDLE->SAVE_EPC->SAVE_CAUSE->VECTOR->IDLE, one cycle per state.
REQ-022 SAVE_EPC SHALL drive c0_write=1, c0_dst=10, c0_wdata=pc_cur and ie_clr=1.
REQ-023 SAVE_CAUSE SHALL drive c0_write=1, c0_dst=01 and c0_wdata=cause_q.
REQ-024 VECTOR SHALL drive pc_write=1 and pc_next to the vector address; for an interrupt it SHALL drive irq_ack one-hot at idx_q, otherwise 0.
REQ-025 A return SHALL sequence IDLE->ERET_RD (c0_dst=10, no write)->ERET_JMP (pc_write=1, pc_next=epc_in, ie_set=1)->IDLE.
REQ-026 When boundary=0, or when the block is busy, requests SHALL be ignored; irq SHALL still accumulate into pend.
REQ-027 An interrupt arriving during a trap SHALL stay pending and, if enabled, be taken at the next boundary after return to IDLE.
REQ-028 Idle output values SHALL be 0 for every strobe, c0_dst=00, c0_wdata=0, pc_next=0 and irq_ack=0.

Reset
REQ-029 rst=1 SHALL force IDLE and clear pend, idx_q and cause_q immediately, aborting any sequence; all outputs SHALL be at idle values.

Configuration
REQ-030 With TRAP_VECTORED_EN defined, the interrupt vector SHALL be VEC_BASE + 8*(idx_q+1) and the syscall vector SHALL be VEC_BASE; without the macro, every trap SHALL vector to VEC_BASE.

Verification
REQ-031 The bench SHALL drive syscall_req with boundary at pc_cur=0x100 and check EPC write 0x100, then cause 0x20, then pc_next=VEC_BASE, with busy high for 3 cycles.
REQ-032 The bench SHALL drive irq=4'b0110 with mask=4'b1111 and ie=1 and check that line 1 is taken with irq_ack=0010; with TRAP_VECTORED_EN, pc_next=0x14.
REQ-033 The bench SHALL drive irq[2] with mask[2]=0 and check that no trap occurs; after setting mask[2], a trap SHALL be taken at the next boundary.
REQ-034 The bench SHALL assert eret_req and syscall_req together with epc_in=0x200 and check that the return wins: pc_next=0x200 and ie_set=1.
REQ-035 The bench SHALL assert rst in SAVE_CAUSE and check IDLE, pend=0 and no pc_write.
REQ-036 The bench SHALL assert irq[0] during VECTOR of a syscall and check that it is taken at the next boundary.
